// File: rtl/imem_boot_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Frame: MAGIC, LEN_LO, LEN_HI, LEN little-endian 32-bit words (+ checksum byte when enabled).
package imem_boot_loader_pkg;

    localparam logic [7:0]  BOOT_MAGIC = 8'hA5;
    localparam int unsigned BOOT_LEN_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        CSUM,
        DONE,
        ERR
    } boot_state_e;

    // Running modulo-256 sum of data bytes.
    function automatic logic [7:0] boot_csum_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

endpackage

// File: rtl/imem_boot_loader_word_packer.sv
// Assembles little-endian 32-bit words from a byte stream.
// word_valid_o is a one-cycle strobe coincident with the fourth byte; clear_i drops any partial word.
module boot_word_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic        word_valid_o,
    output logic [31:0] word_o
);

    logic [1:0]  idx_q;
    logic [23:0] low_q;

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            idx_q <= '0;
            low_q <= '0;
        end else if (byte_valid_i) begin
            idx_q <= idx_q + 2'd1;
            case (idx_q)
                2'd0:    low_q[7:0]   <= byte_i;
                2'd1:    low_q[15:8]  <= byte_i;
                2'd2:    low_q[23:16] <= byte_i;
                default: low_q        <= '0;
            endcase
        end
    end

    // The top byte is taken straight from the input so the word is complete on its last strobe.
    assign word_valid_o = byte_valid_i && (idx_q == 2'd3);
    assign word_o       = {byte_i, low_q};

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: parses a UART byte frame into instruction-memory writes and holds the core in reset meanwhile.
// Optional checksum byte after the data is enabled with `define BOOT_CHECKSUM_EN.
module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter int unsigned ADDR_W         = 10,
    parameter int unsigned DEPTH          = 1024,
    parameter logic [7:0]  MAGIC          = BOOT_MAGIC,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_byte,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst,
    output logic              load_busy,
    output logic              load_done,
    output logic              load_err
);

    localparam int unsigned           TMR_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0]      TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [BOOT_LEN_W-1:0] DEPTH_L  = BOOT_LEN_W'(DEPTH);

    boot_state_e           state_q;
    logic [BOOT_LEN_W-1:0] len_q;
    logic [BOOT_LEN_W-1:0] widx_q;
    logic [TMR_W-1:0]      timer_q;
    logic                  imem_we_q;
    logic [ADDR_W-1:0]     imem_addr_q;
    logic [31:0]           imem_wdata_q;
    logic                  core_rst_q;
    logic                  load_busy_q;
    logic                  load_done_q;
    logic                  load_err_q;
`ifdef BOOT_CHECKSUM_EN
    logic [7:0]            csum_q;
`endif

    logic                  pk_clear;
    logic                  pk_valid;
    logic                  pk_word_valid;
    logic [31:0]           pk_word;
    logic [BOOT_LEN_W-1:0] len_w;
    logic                  is_magic;

    assign pk_clear = (state_q != DATA);
    assign pk_valid = rx_valid && (state_q == DATA);
    assign len_w    = {rx_byte, len_q[7:0]};
    assign is_magic = rx_valid && (rx_byte == MAGIC);

    boot_word_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (pk_clear),
        .byte_valid_i (pk_valid),
        .byte_i       (rx_byte),
        .word_valid_o (pk_word_valid),
        .word_o       (pk_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            len_q        <= '0;
            widx_q       <= '0;
            timer_q      <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            core_rst_q   <= 1'b1;
            load_busy_q  <= 1'b0;
            load_done_q  <= 1'b0;
            load_err_q   <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
            csum_q       <= '0;
`endif
        end else begin
            imem_we_q <= 1'b0;
            // Address advances the cycle after each write pulse, so the pulse shows the word index.
            if (imem_we_q) begin
                imem_addr_q <= imem_addr_q + ADDR_W'(1);
            end

            case (state_q)
                IDLE, DONE, ERR: begin
                    timer_q <= '0;
                    if (state_q == DONE) begin
                        core_rst_q  <= 1'b0;
                        load_done_q <= 1'b1;
                        load_busy_q <= 1'b0;
                    end
                    if (is_magic) begin
                        state_q     <= LEN_LO;
                        load_busy_q <= 1'b1;
                        load_done_q <= 1'b0;
                        load_err_q  <= 1'b0;
                        core_rst_q  <= 1'b1;
`ifdef BOOT_CHECKSUM_EN
                        csum_q      <= '0;
`endif
                    end
                end

                default: begin
                    if (rx_valid) begin
                        timer_q <= '0;
                        case (state_q)
                            LEN_LO: begin
                                len_q[7:0] <= rx_byte;
                                state_q    <= LEN_HI;
                            end

                            LEN_HI: begin
                                len_q <= len_w;
                                if (len_w == '0) begin
`ifdef BOOT_CHECKSUM_EN
                                    state_q <= CSUM;
`else
                                    state_q <= DONE;
`endif
                                end else if (len_w > DEPTH_L) begin
                                    state_q     <= ERR;
                                    load_err_q  <= 1'b1;
                                    core_rst_q  <= 1'b1;
                                    load_busy_q <= 1'b0;
                                end else begin
                                    state_q     <= DATA;
                                    imem_addr_q <= '0;
                                    widx_q      <= '0;
                                end
                            end

                            DATA: begin
`ifdef BOOT_CHECKSUM_EN
                                csum_q <= boot_csum_add(csum_q, rx_byte);
`endif
                                if (pk_word_valid) begin
                                    imem_we_q    <= 1'b1;
                                    imem_wdata_q <= pk_word;
                                    widx_q       <= widx_q + BOOT_LEN_W'(1);
                                    if (widx_q == len_q - BOOT_LEN_W'(1)) begin
`ifdef BOOT_CHECKSUM_EN
                                        state_q <= CSUM;
`else
                                        state_q <= DONE;
`endif
                                    end
                                end
                            end

`ifdef BOOT_CHECKSUM_EN
                            CSUM: begin
                                if (rx_byte == csum_q) begin
                                    state_q <= DONE;
                                end else begin
                                    state_q     <= ERR;
                                    load_err_q  <= 1'b1;
                                    core_rst_q  <= 1'b1;
                                    load_busy_q <= 1'b0;
                                end
                            end
`endif

                            default: ;
                        endcase
                    end else if (timer_q == TMR_LAST) begin
                        state_q     <= ERR;
                        load_err_q  <= 1'b1;
                        core_rst_q  <= 1'b1;
                        load_busy_q <= 1'b0;
                    end else begin
                        timer_q <= timer_q + TMR_W'(1);
                    end
                end
            endcase
        end
    end

    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign core_rst   = core_rst_q;
    assign load_busy  = load_busy_q;
    assign load_done  = load_done_q;
    assign load_err   = load_err_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: frames built from word lists, writes scored against the frame contents.
// Honours `define BOOT_CHECKSUM_EN by appending the checksum byte.
module tb_imem_boot_loader;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1024;
    localparam int T      = 40;
`ifdef BOOT_CHECKSUM_EN
    localparam int FALL_LAT = 3;
`else
    localparam int FALL_LAT = 1;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_byte = 8'h00;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_rst;
    logic              load_busy;
    logic              load_done;
    logic              load_err;

    int checks = 0;
    int errors = 0;

    int unsigned       ncyc = 0;
    int unsigned       last_we_cyc = 0;
    int unsigned       fall_cyc = 0;
    logic              prev_core_rst = 1'b1;
    logic [ADDR_W-1:0] cap_addr[$];
    logic [31:0]       cap_data[$];
    logic [31:0]       words[$];

    imem_boot_loader #(
        .ADDR_W         (ADDR_W),
        .DEPTH          (DEPTH),
        .MAGIC          (8'hA5),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_valid   (rx_valid),
        .rx_byte    (rx_byte),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_rst   (core_rst),
        .load_busy  (load_busy),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        ncyc = ncyc + 1;
        if (imem_we === 1'b1) begin
            cap_addr.push_back(imem_addr);
            cap_data.push_back(imem_wdata);
            last_we_cyc = ncyc;
        end
        if (prev_core_rst === 1'b1 && core_rst === 1'b0) fall_cyc = ncyc;
        prev_core_rst = core_rst;
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_valid = 1'b1;
        rx_byte  = b;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (gap - 1) @(negedge clk);
    endtask

    // Sends MAGIC, LEN and, for a legal LEN, the words in `words` plus checksum (+adj).
    task automatic send_frame(input int len, input int gap, input logic [7:0] adj);
        logic [15:0] l;
        logic [31:0] w;
        logic [7:0]  sum;
        l   = len[15:0];
        sum = 8'h00;
        send_byte(8'hA5, gap);
        send_byte(l[7:0], gap);
        send_byte(l[15:8], gap);
        if (len <= DEPTH) begin
            for (int i = 0; i < len; i++) begin
                w = words[i];
                for (int k = 0; k < 4; k++) begin
                    send_byte(w[8*k +: 8], gap);
                    sum = sum + w[8*k +: 8];
                end
            end
`ifdef BOOT_CHECKSUM_EN
            send_byte(sum + adj, gap);
`endif
        end
    endtask

    task automatic clear_capture();
        cap_addr.delete();
        cap_data.delete();
    endtask

    task automatic test_reset();
        checks++; if (core_rst !== 1'b1) begin errors++; $display("FAIL reset_core_rst: got %b want 1", core_rst); end
        checks++; if (imem_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", imem_we); end
        checks++; if (imem_addr !== '0) begin errors++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
        checks++; if (imem_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h want 0", imem_wdata); end
        checks++; if ({load_busy, load_done, load_err} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {load_busy, load_done, load_err}); end
    endtask

    task automatic test_ignore_preamble();
        clear_capture();
        send_byte(8'h00, 2);
        send_byte(8'hFF, 2);
        send_byte(8'h12, 3);
        checks++; if (cap_addr.size() !== 0) begin errors++; $display("FAIL preamble_writes: got %0d want 0", cap_addr.size()); end
        checks++; if (core_rst !== 1'b1) begin errors++; $display("FAIL preamble_core_rst: got %b want 1", core_rst); end
        checks++; if ({load_busy, load_done, load_err} !== 3'b000) begin errors++; $display("FAIL preamble_flags: got %b want 000", {load_busy, load_done, load_err}); end
    endtask

    task automatic test_spec_frame();
        clear_capture();
        words.delete();
        words.push_back(32'h00000013);
        words.push_back(32'h00500093);
        fall_cyc = 0;
        send_frame(2, 2, 8'h00);
        repeat (4) @(negedge clk);
        checks++; if (cap_addr.size() !== 2) begin errors++; $display("FAIL spec_count: got %0d want 2", cap_addr.size()); end
        for (int i = 0; i < 2 && i < cap_addr.size(); i++) begin
            checks++;
            if (cap_addr[i] !== ADDR_W'(i) || cap_data[i] !== words[i]) begin
                errors++; $display("FAIL spec_write%0d: got %h/%h want %h/%h", i, cap_addr[i], cap_data[i], ADDR_W'(i), words[i]);
            end
        end
        checks++; if (fall_cyc - last_we_cyc !== FALL_LAT) begin errors++; $display("FAIL spec_rst_fall: got %0d want %0d", fall_cyc - last_we_cyc, FALL_LAT); end
        checks++; if ({core_rst, load_busy, load_done, load_err} !== 4'b0010) begin errors++; $display("FAIL spec_flags: got %b want 0010", {core_rst, load_busy, load_done, load_err}); end
    endtask

    task automatic test_reload_len0();
        clear_capture();
        rx_valid = 1'b1;
        rx_byte  = 8'hA5;
        checks++; if (core_rst !== 1'b0) begin errors++; $display("FAIL reload_pre: got %b want 0", core_rst); end
        @(negedge clk);
        rx_valid = 1'b0;
        checks++; if (core_rst !== 1'b1 || load_busy !== 1'b1) begin errors++; $display("FAIL reload_rise: got %b%b want 11", core_rst, load_busy); end
        @(negedge clk);
        send_byte(8'h00, 2);
        send_byte(8'h00, 2);
`ifdef BOOT_CHECKSUM_EN
        send_byte(8'h00, 2);
`endif
        repeat (3) @(negedge clk);
        checks++; if ({core_rst, load_busy, load_done, load_err} !== 4'b0010) begin errors++; $display("FAIL reload_done: got %b want 0010", {core_rst, load_busy, load_done, load_err}); end
        checks++; if (cap_addr.size() !== 0) begin errors++; $display("FAIL reload_writes: got %0d want 0", cap_addr.size()); end
    endtask

    task automatic test_random_frames();
        int          len;
        int          gap;
        logic [7:0]  junk;
        for (int f = 0; f < 5; f++) begin
            words.delete();
            len = $urandom_range(1, 8);
            gap = $urandom_range(2, 4);
            for (int i = 0; i < len; i++) words.push_back($urandom);
            junk = 8'($urandom_range(0, 255));
            if (junk == 8'hA5) junk = 8'h5A;
            send_byte(junk, 2);
            clear_capture();
            send_frame(len, gap, 8'h00);
            repeat (4) @(negedge clk);
            checks++; if (cap_addr.size() !== len) begin errors++; $display("FAIL rand%0d_count: got %0d want %0d", f, cap_addr.size(), len); end
            for (int i = 0; i < len && i < cap_addr.size(); i++) begin
                checks++;
                if (cap_addr[i] !== ADDR_W'(i) || cap_data[i] !== words[i]) begin
                    errors++; $display("FAIL rand%0d_write%0d: got %h/%h want %h/%h", f, i, cap_addr[i], cap_data[i], ADDR_W'(i), words[i]);
                end
            end
            checks++; if ({core_rst, load_busy, load_done, load_err} !== 4'b0010) begin errors++; $display("FAIL rand%0d_flags: got %b want 0010", f, {core_rst, load_busy, load_done, load_err}); end
        end
    endtask

    task automatic test_magic_in_data();
        words.delete();
        words.push_back(32'hA5A5A5A5);
        words.push_back(32'h000000A5);
        clear_capture();
        send_frame(2, 2, 8'h00);
        repeat (4) @(negedge clk);
        checks++; if (cap_addr.size() !== 2) begin errors++; $display("FAIL magic_data_count: got %0d want 2", cap_addr.size()); end
        for (int i = 0; i < 2 && i < cap_addr.size(); i++) begin
            checks++;
            if (cap_addr[i] !== ADDR_W'(i) || cap_data[i] !== words[i]) begin
                errors++; $display("FAIL magic_data_write%0d: got %h/%h want %h/%h", i, cap_addr[i], cap_data[i], ADDR_W'(i), words[i]);
            end
        end
        checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL magic_data_done: got %b want 1", load_done); end
    endtask

    task automatic test_timeout();
        clear_capture();
        send_byte(8'hA5, 2);
        send_byte(8'h01, 2);
        send_byte(8'h00, 2);
        send_byte(8'h13, 2);
        send_byte(8'h00, 2);
        repeat (T + 5) @(negedge clk);
        checks++; if ({core_rst, load_busy, load_done, load_err} !== 4'b1001) begin errors++; $display("FAIL timeout_flags: got %b want 1001", {core_rst, load_busy, load_done, load_err}); end
        checks++; if (cap_addr.size() !== 0) begin errors++; $display("FAIL timeout_writes: got %0d want 0", cap_addr.size()); end
        words.delete();
        words.push_back($urandom);
        send_frame(1, 2, 8'h00);
        repeat (4) @(negedge clk);
        checks++; if ({core_rst, load_busy, load_done, load_err} !== 4'b0010) begin errors++; $display("FAIL timeout_recover: got %b want 0010", {core_rst, load_busy, load_done, load_err}); end
        checks++; if (cap_addr.size() !== 1 || cap_data[0] !== words[0]) begin errors++; $display("FAIL timeout_recover_write: got %0d writes want 1 of %h", cap_addr.size(), words[0]); end
    endtask

    task automatic test_timeout_boundary();
        words.delete();
        words.push_back($urandom);
        clear_capture();
        send_frame(1, T, 8'h00);
        repeat (3) @(negedge clk);
        checks++; if ({load_done, load_err} !== 2'b10) begin errors++; $display("FAIL gap_at_limit: got %b want 10", {load_done, load_err}); end
        checks++; if (cap_addr.size() !== 1) begin errors++; $display("FAIL gap_at_limit_writes: got %0d want 1", cap_addr.size()); end
        clear_capture();
        send_frame(1, T + 1, 8'h00);
        repeat (3) @(negedge clk);
        checks++; if ({core_rst, load_done, load_err} !== 3'b101) begin errors++; $display("FAIL gap_over_limit: got %b want 101", {core_rst, load_done, load_err}); end
        checks++; if (cap_addr.size() !== 0) begin errors++; $display("FAIL gap_over_limit_writes: got %0d want 0", cap_addr.size()); end
    endtask

    task automatic test_oversize();
        clear_capture();
        send_frame(DEPTH + 1, 2, 8'h00);
        repeat (4) @(negedge clk);
        checks++; if ({core_rst, load_busy, load_done, load_err} !== 4'b1001) begin errors++; $display("FAIL oversize_flags: got %b want 1001", {core_rst, load_busy, load_done, load_err}); end
        checks++; if (cap_addr.size() !== 0) begin errors++; $display("FAIL oversize_writes: got %0d want 0", cap_addr.size()); end
    endtask

    task automatic test_max_len();
        int bad;
        words.delete();
        for (int i = 0; i < DEPTH; i++) words.push_back($urandom);
        clear_capture();
        send_frame(DEPTH, 2, 8'h00);
        repeat (4) @(negedge clk);
        checks++; if (cap_addr.size() !== DEPTH) begin errors++; $display("FAIL maxlen_count: got %0d want %0d", cap_addr.size(), DEPTH); end
        bad = 0;
        for (int i = 0; i < DEPTH && i < cap_addr.size(); i++) begin
            if (cap_addr[i] !== ADDR_W'(i) || cap_data[i] !== words[i]) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL maxlen_writes: got %0d wrong words want 0", bad); end
        checks++; if ({core_rst, load_done, load_err} !== 3'b010) begin errors++; $display("FAIL maxlen_flags: got %b want 010", {core_rst, load_done, load_err}); end
    endtask

    task automatic test_midframe_reset();
        send_byte(8'hA5, 2);
        send_byte(8'h02, 2);
        send_byte(8'h00, 2);
        send_byte(8'h11, 2);
        send_byte(8'h22, 2);
        send_byte(8'h33, 2);
        send_byte(8'h44, 2);
        send_byte(8'h55, 2);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if ({core_rst, imem_we, load_busy, load_done, load_err} !== 5'b10000) begin errors++; $display("FAIL midrst_flags: got %b want 10000", {core_rst, imem_we, load_busy, load_done, load_err}); end
        checks++; if (imem_addr !== '0 || imem_wdata !== 32'h0) begin errors++; $display("FAIL midrst_regs: got %h/%h want 0/0", imem_addr, imem_wdata); end
        rst = 1'b0;
        @(negedge clk);
        clear_capture();
        words.delete();
        words.push_back($urandom);
        send_frame(1, 2, 8'h00);
        repeat (4) @(negedge clk);
        checks++; if (cap_addr.size() !== 1 || cap_addr[0] !== '0 || cap_data[0] !== words[0]) begin errors++; $display("FAIL midrst_reload: got %0d writes want 1 of %h at 0", cap_addr.size(), words[0]); end
        checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL midrst_done: got %b want 1", load_done); end
    endtask

`ifdef BOOT_CHECKSUM_EN
    task automatic test_checksum();
        words.delete();
        words.push_back(32'h04030201);
        clear_capture();
        send_frame(1, 2, 8'h00);
        repeat (4) @(negedge clk);
        checks++; if ({core_rst, load_done, load_err} !== 3'b010) begin errors++; $display("FAIL csum_good: got %b want 010", {core_rst, load_done, load_err}); end
        checks++; if (cap_addr.size() !== 1 || cap_data[0] !== 32'h04030201) begin errors++; $display("FAIL csum_good_write: got %0d writes want 1", cap_addr.size()); end
        send_frame(1, 2, 8'h01);
        repeat (4) @(negedge clk);
        checks++; if ({core_rst, load_done, load_err} !== 3'b101) begin errors++; $display("FAIL csum_bad: got %b want 101", {core_rst, load_done, load_err}); end
        words.delete();
        send_frame(0, 2, 8'h01);
        repeat (4) @(negedge clk);
        checks++; if ({core_rst, load_done, load_err} !== 3'b101) begin errors++; $display("FAIL csum_len0_bad: got %b want 101", {core_rst, load_done, load_err}); end
    endtask
`endif

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        @(negedge clk);
        test_ignore_preamble();
        test_spec_frame();
        test_reload_len0();
        test_random_frames();
        test_magic_in_data();
        test_timeout();
        test_timeout_boundary();
        test_oversize();
        test_max_len();
        test_midframe_reset();
`ifdef BOOT_CHECKSUM_EN
        test_checksum();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Sequences loading of the instruction memory from the UART receive path (`rx_serial`, after byte deserialisation) and holds the pipeline in reset while loading.
- Parses a framed byte stream: magic, word count, little-endian instruction words.
- Drives the instruction-memory write port, then releases the core so fetch starts at PC 0.
- Sits in `top` between the UART byte receiver and `instruction_fetch_stage`'s memory write port / reset.

Parameters:
- `ADDR_W`, 10, instruction-memory word-address width.
- `DEPTH`, 1024, maximum loadable words (must be ≤ 2^ADDR_W).
- `MAGIC`, 8'hA5, frame-start byte.
- `TIMEOUT_CYCLES`, 1_000_000, max idle clocks between bytes inside a frame.

Ports:
- `clk`, input, 1, core clock.
- `rst`, input, 1, reset; synchronous, active-high.
- `rx_valid`, input, 1, one-cycle strobe: `rx_byte` holds a new received byte.
- `rx_byte`, input, 8, received byte.
- `imem_we`, output, 1, instruction-memory write enable (one-cycle pulse).
- `imem_addr`, output, `ADDR_W`, word address for the write.
- `imem_wdata`, output, 32, instruction word.
- `core_rst`, output, 1, reset to pipeline stages; active-high.
- `load_busy`, output, 1, high while a frame is in progress.
- `load_done`, output, 1, high while the core is released after a good load.
- `load_err`, output, 1, sticky error flag; cleared by the next magic byte.

Behaviour:
- Reset values:
  - `state` = IDLE, `core_rst` = 1, `imem_we` = 0.
  - `imem_addr` = 0, `imem_wdata` = 0.
  - `load_busy` = 0, `load_done` = 0, `load_err` = 0.
  - Word count, byte index and timeout counter = 0.
- Frame format: MAGIC, LEN_LO, LEN_HI, then LEN words of 4 bytes each, least-significant byte first.
- States and transitions:
  - IDLE: non-MAGIC bytes are ignored. MAGIC → LEN_LO; set `load_busy` = 1, clear `load_err`, `core_rst` = 1.
  - LEN_LO: capture the low byte → LEN_HI.
  - LEN_HI: form LEN.
    - LEN = 0 → DONE.
    - LEN > `DEPTH` → ERR.
    - Otherwise → DATA with `imem_addr` = 0, byte index = 0.
  - DATA:
    - Shift each byte into `imem_wdata[8*idx +: 8]`.
    - On the 4th byte, pulse `imem_we` for exactly 1 cycle, in the cycle after that byte's `rx_valid`, with `imem_addr` = word index.
    - Then increment the address.
    - After word LEN−1 is written → DONE (or CSUM when the optional feature is enabled).
  - DONE: `core_rst` = 0, `load_done` = 1, `load_busy` = 0. `core_rst` falls the cycle after the final `imem_we` pulse. A MAGIC byte → LEN_LO and reasserts `core_rst` the next cycle (reload mid-run). Other bytes are ignored.
  - ERR: `load_err` = 1, `core_rst` = 1, `load_busy` = 0. MAGIC → LEN_LO.
- Timeout:
  - The counter resets on every `rx_valid` and counts only in LEN_LO, LEN_HI, DATA and CSUM.
  - Reaching `TIMEOUT_CYCLES` → ERR.
  - Partial words are discarded; words already written stay in memory.
- A MAGIC value received inside LEN/DATA/CSUM is treated as data, not a restart.
- `rx_valid` arriving in the same cycle as the timeout: the byte wins and the counter clears.
- `rst` asserted mid-frame: immediate return to reset values; the frame is abandoned.
- Bytes are never back-pressured; the receiver sends at most one byte every 2 clocks.

Optional Feature:
- Macro `BOOT_CHECKSUM_EN`.
- Defined:
  - An extra byte follows the data (state CSUM).
  - The 8-bit modulo-256 sum of all data bytes must equal this byte.
  - Match → DONE; mismatch → ERR.
  - With LEN = 0 the checksum byte is still required and must be 8'h00.
- Undefined: no CSUM state; DATA goes directly to DONE.

Decomposition:
- Add to `common_pkg`:
  - `boot_state_e` enum (IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR).
  - `BOOT_MAGIC` constant.
  - `BOOT_LEN_W` = 16.
- Sub-module `boot_word_packer`: byte index counter plus 32-bit little-endian assembly. Outputs `word_valid` (one-cycle) and `word`; cleared by a `clear` input.

Test Plan:
- Reset, then bytes A5 02 00 13 00 00 00 93 00 50 00 → writes (addr 0, 32'h00000013) and (addr 1, 32'h00500093). `core_rst` falls 1 cycle after the 2nd write; `load_done` = 1.
- Bytes 00 FF 12 before the magic → no writes, state stays IDLE, `core_rst` = 1.
- A5 01 00 13 00, then no bytes for `TIMEOUT_CYCLES` → `load_err` = 1, `core_rst` = 1, no write. A following complete frame succeeds and clears `load_err`.
- A5 01 04 (LEN = 1025 > `DEPTH`) → ERR, no writes.
- After DONE with the core running, send A5 00 00 → `core_rst` rises the cycle after the magic, then falls again (LEN = 0 → DONE).
- With `BOOT_CHECKSUM_EN`:
  - A5 01 00 01 02 03 04 0A → DONE.
  - The same frame with a final byte of 0B → ERR; `core_rst` stays 1.
